gelato_wb_arbiter: RTL and testbench
====================================

GELATO_WB_ARBITER -- requirements
Module: gelato_wb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3: number of execution-unit writeback sources (0 compute, 1 load/store, 2 tensor).
REQ-002 Parameter THREADS, default 32: lanes per warp.
REQ-003 Parameter DATA_W, default 32: bits per lane.
REQ-004 Parameter WARP_ID_W, default 4: warp index width.
REQ-005 Parameter REG_ADDR_W, default 5: destination register index width.
REQ-006 Parameter DEPTH, default 2: per-source buffer entries (power of two).
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 rdy  in  1  global enable; low freezes all state.
REQ-010 src_valid  in  NUM_SRC  per-source writeback request.
REQ-011 src_ready  out  NUM_SRC  per-source accept.
REQ-012 src_warp_id  in  NUM_SRC*WARP_ID_W  warp of each request.
REQ-013 src_rd  in  NUM_SRC*REG_ADDR_W  destination register.
REQ-014 src_mask  in  NUM_SRC*THREADS  lane write-enable.
REQ-015 src_data  in  NUM_SRC*THREADS*DATA_W  lane data.
REQ-016 wb_valid  out  1  one writeback to register file and dispatch scoreboard this cycle.
REQ-017 wb_warp_id / wb_rd / wb_mask / wb_data  out  WARP_ID_W / REG_ADDR_W / THREADS / THREADS*DATA_W  selected writeback; no back-pressure from consumer.

Function
REQ-018 Each source SHALL own a DEPTH-entry FIFO; push on src_valid & src_ready & rdy.
REQ-019 src_ready[i] SHALL equal (count[i] != DEPTH), derived from the registered count only; a full FIFO SHALL not accept even if popped in the same cycle.
REQ-020 Push and pop on the same FIFO in one cycle SHALL leave count unchanged and preserve order.
REQ-021 Arbitration SHALL be round-robin: grant the first non-empty FIFO at index >= rr_ptr, wrapping modulo NUM_SRC; on grant rr_ptr <= (grant+1) mod NUM_SRC.
REQ-022 At most one FIFO SHALL pop per cycle; no pop and no rr_ptr change when all FIFOs are empty.
REQ-023 wb_* outputs SHALL be registered: the popped entry appears on wb_* the cycle after the pop, with wb_valid high for exactly one cycle per entry.
REQ-024 Minimum latency SHALL be 2 cycles: src_valid accepted at edge N -> wb_valid high after edge N+2... i.e. sampled at edge N+2.
REQ-025 With no grant, wb_valid SHALL be 0 next cycle and wb_warp_id/rd/mask/data SHALL hold their previous values.
REQ-026 Entries with src_mask all zero SHALL still be forwarded (scoreboard release).
REQ-027 With rdy low: no push, no pop, rr_ptr, counts, FIFO contents and all wb_* outputs hold; src_ready still reflects count.
REQ-028 Throughput SHALL be one writeback per cycle whenever any FIFO is non-empty.

Reset
REQ-029 rst_n low SHALL asynchronously clear all FIFO counts and pointers, rr_ptr to 0, wb_valid to 0, wb_warp_id/rd/mask/data to 0; src_ready SHALL read all ones once reset is deasserted.
REQ-030 Reset mid-operation SHALL discard all buffered entries; no wb_valid SHALL be issued for them.

Structure
REQ-031 Writeback record typedef (warp_id, rd, mask, data) and the width constants SHALL live in gelato_pkg, shared with register file, dispatch and execution units.
REQ-032 Per-source buffering SHALL be one sub-module, gelato_wb_fifo, instantiated NUM_SRC times; arbiter and output register stay in the top.

Verification
REQ-033 Single source: src 1 pushes warp 3, rd 7, mask 0xFFFFFFFF, data lane k = k -> wb_valid exactly 2 cycles later with identical fields, one cycle wide.
REQ-034 Contention: all three sources push one entry in the same cycle -> wb order src 0, 1, 2 on consecutive cycles; next single src 0 request granted with rr_ptr = 0.
REQ-035 Full: src 0 pushes 3 back-to-back while src 1/2 keep one FIFO each busy -> src_ready[0] low after 2 accepted, third accepted only after a pop; no loss, order preserved.
REQ-036 rdy low for 4 cycles with entries pending -> wb_* frozen, no pops; on rdy high, draining resumes at the same rr_ptr.
REQ-037 Reset asserted with 2 entries buffered in src 2 -> wb_valid 0 immediately, no writeback after release, src_ready = 3'b111.
REQ-038 Zero mask: src 0 pushes mask 0 -> wb_valid pulse with wb_mask 0.

Source files
------------

// File: rtl/gelato_pkg.sv
// Shared writeback definitions used by the register file, dispatch, execution units and the writeback arbiter.
package gelato_pkg;

    localparam int unsigned WB_NUM_SRC    = 3;
    localparam int unsigned WB_THREADS    = 32;
    localparam int unsigned WB_DATA_W     = 32;
    localparam int unsigned WB_WARP_ID_W  = 4;
    localparam int unsigned WB_REG_ADDR_W = 5;
    localparam int unsigned WB_DEPTH      = 2;

    // Field order matches the flat {warp_id, rd, mask, data} layout buffered by the arbiter.
    typedef struct packed {
        logic [WB_WARP_ID_W-1:0]         warp_id;
        logic [WB_REG_ADDR_W-1:0]        rd;
        logic [WB_THREADS-1:0]           mask;
        logic [WB_THREADS*WB_DATA_W-1:0] data;
    } wb_rec_t;

    localparam int unsigned WB_REC_W = $bits(wb_rec_t);

endpackage

// File: rtl/gelato_wb_fifo.sv
// Per-source writeback buffer: DEPTH-entry FIFO with registered occupancy and a show-ahead head.
module gelato_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gelato_wb_arbiter.sv
// Writeback arbiter: buffers each execution unit's results and issues one registered
// writeback per cycle to the register file and dispatch scoreboard, round-robin across sources.
module gelato_wb_arbiter
    import gelato_pkg::*;
#(
    parameter int unsigned NUM_SRC    = WB_NUM_SRC,
    parameter int unsigned THREADS    = WB_THREADS,
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned WARP_ID_W  = WB_WARP_ID_W,
    parameter int unsigned REG_ADDR_W = WB_REG_ADDR_W,
    parameter int unsigned DEPTH      = WB_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rdy,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC*WARP_ID_W-1:0]        src_warp_id,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]       src_rd,
    input  logic [NUM_SRC*THREADS-1:0]          src_mask,
    input  logic [NUM_SRC*THREADS*DATA_W-1:0]   src_data,
    output logic                                wb_valid,
    output logic [WARP_ID_W-1:0]                wb_warp_id,
    output logic [REG_ADDR_W-1:0]               wb_rd,
    output logic [THREADS-1:0]                  wb_mask,
    output logic [THREADS*DATA_W-1:0]           wb_data
);

    localparam int unsigned LANE_W = THREADS * DATA_W;
    localparam int unsigned REC_W  = WARP_ID_W + REG_ADDR_W + THREADS + LANE_W;
    localparam int unsigned RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [REC_W-1:0]   head [NUM_SRC];

    logic [RR_W-1:0]    rr_ptr;
    logic               grant_valid;
    logic [RR_W-1:0]    grant_idx;

    // Ready comes from registered occupancy only, so a full FIFO never accepts on its pop cycle.
    for (genvar i = 0; i < NUM_SRC; i++) begin : gen_src
        logic [REC_W-1:0] din;

        assign src_ready[i] = ~full[i];
        assign push[i]      = src_valid[i] & ~full[i] & rdy;
        assign pop[i]       = rdy & grant_valid & (grant_idx == RR_W'(i));
        assign din          = {src_warp_id[i*WARP_ID_W +: WARP_ID_W],
                               src_rd[i*REG_ADDR_W +: REG_ADDR_W],
                               src_mask[i*THREADS +: THREADS],
                               src_data[i*LANE_W +: LANE_W]};

        gelato_wb_fifo #(
            .WIDTH (REC_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .din     (din),
            .head_c  (head[i]),
            .full_c  (full[i]),
            .empty_c (empty[i])
        );
    end

    // First non-empty source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        logic [RR_W:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (RR_W + 1)'(k);
            if (cand >= (RR_W + 1)'(NUM_SRC)) begin
                cand = cand - (RR_W + 1)'(NUM_SRC);
            end
            if (!grant_valid && !empty[cand[RR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
    end

    // Output register; payload holds when nothing is granted, everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            wb_valid   <= 1'b0;
            wb_warp_id <= '0;
            wb_rd      <= '0;
            wb_mask    <= '0;
            wb_data    <= '0;
        end else if (rdy) begin
            wb_valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr <= (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + RR_W'(1);
                {wb_warp_id, wb_rd, wb_mask, wb_data} <= head[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Directed bench for the writeback arbiter: a queue holds writebacks in their required issue order.
module tb_gelato_wb_arbiter;
    import gelato_pkg::*;

    localparam int unsigned NS = WB_NUM_SRC;
    localparam int unsigned LW = WB_THREADS * WB_DATA_W;

    logic                          clk;
    logic                          rst_n;
    logic                          rdy;
    logic [NS-1:0]                 src_valid;
    logic [NS-1:0]                 src_ready;
    logic [NS*WB_WARP_ID_W-1:0]    src_warp_id;
    logic [NS*WB_REG_ADDR_W-1:0]   src_rd;
    logic [NS*WB_THREADS-1:0]      src_mask;
    logic [NS*LW-1:0]              src_data;
    logic                          wb_valid;
    logic [WB_WARP_ID_W-1:0]       wb_warp_id;
    logic [WB_REG_ADDR_W-1:0]      wb_rd;
    logic [WB_THREADS-1:0]         wb_mask;
    logic [LW-1:0]                 wb_data;

    int checks  = 0;
    int errors  = 0;
    int pulses  = 0;
    int pushed  = 0;
    wb_rec_t sb[$];

    gelato_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_warp_id (src_warp_id),
        .src_rd      (src_rd),
        .src_mask    (src_mask),
        .src_data    (src_data),
        .wb_valid    (wb_valid),
        .wb_warp_id  (wb_warp_id),
        .wb_rd       (wb_rd),
        .wb_mask     (wb_mask),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wb_rec_t mk(input int w, input int r, input logic [WB_THREADS-1:0] m, input int seed);
        wb_rec_t rec;
        rec.warp_id = WB_WARP_ID_W'(w);
        rec.rd      = WB_REG_ADDR_W'(r);
        rec.mask    = m;
        for (int k = 0; k < WB_THREADS; k++) begin
            rec.data[k*WB_DATA_W +: WB_DATA_W] = WB_DATA_W'(seed + k);
        end
        return rec;
    endfunction

    task automatic set_src(input int i, input wb_rec_t r);
        src_warp_id[i*WB_WARP_ID_W +: WB_WARP_ID_W]   = r.warp_id;
        src_rd[i*WB_REG_ADDR_W +: WB_REG_ADDR_W]      = r.rd;
        src_mask[i*WB_THREADS +: WB_THREADS]          = r.mask;
        src_data[i*LW +: LW]                          = r.data;
        src_valid[i]                                  = 1'b1;
    endtask

    task automatic expect_wb(input wb_rec_t r);
        sb.push_back(r);
        pushed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A writeback is consumed on an edge where rdy is high; frozen cycles do not repeat it.
    always @(negedge clk) begin
        wb_rec_t got;
        wb_rec_t exp_rec;
        if (rst_n && rdy && wb_valid) begin
            pulses++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed writeback rd %0d warp %0d, expected none", wb_rd, wb_warp_id);
            end
            if (sb.size() != 0) begin
                exp_rec = sb.pop_front();
                got     = '{warp_id: wb_warp_id, rd: wb_rd, mask: wb_mask, data: wb_data};
                checks++;
                assert (got === exp_rec) else begin
                    errors++;
                    $error("FAIL sb_record: observed warp %0d rd %0d mask %0h data_ok %0b, expected warp %0d rd %0d mask %0h",
                           got.warp_id, got.rd, got.mask, got.data === exp_rec.data,
                           exp_rec.warp_id, exp_rec.rd, exp_rec.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rec_t r1, r2, c0, c1, c2, d0;
        wb_rec_t s0a, s0b, s0c, s1a, s1b, s2a, s2b;
        wb_rec_t s0x, s2x, junk, z;

        rst_n = 1'b0; rdy = 1'b1;
        src_valid = '0; src_warp_id = '0; src_rd = '0; src_mask = '0; src_data = '0;
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        step(); step();
        rst_n = 1'b1;
        check("rst_ready",   64'(src_ready),  64'h7);
        check("rst_warp",    64'(wb_warp_id), 64'd0);
        check("rst_rd",      64'(wb_rd),      64'd0);
        check("rst_mask",    64'(wb_mask),    64'd0);
        check("rst_data",    64'(wb_data == '0), 64'd1);

        // Single source, two-cycle latency, one-cycle pulse
        r1 = mk(3, 7, 32'hFFFF_FFFF, 0);
        expect_wb(r1); set_src(1, r1);
        step(); src_valid = '0;
        check("t1_lat_n",    64'(wb_valid), 64'd0);
        step();
        check("t1_valid",    64'(wb_valid), 64'd1);
        check("t1_rd",       64'(wb_rd), 64'd7);
        check("t1_warp",     64'(wb_warp_id), 64'd3);
        check("t1_lane5",    64'(wb_data[5*WB_DATA_W +: WB_DATA_W]), 64'd5);
        step();
        check("t1_width",    64'(wb_valid), 64'd0);

        // Grant src 2 so the pointer returns to 0, then three-way contention
        r2 = mk(1, 2, 32'hFFFF_0000, 100);
        expect_wb(r2); set_src(2, r2);
        step(); src_valid = '0;
        step(); step(); step();
        c0 = mk(4, 10, 32'h0000_00FF, 200);
        c1 = mk(5, 11, 32'h0000_FF00, 300);
        c2 = mk(6, 12, 32'h00FF_0000, 400);
        expect_wb(c0); expect_wb(c1); expect_wb(c2);
        set_src(0, c0); set_src(1, c1); set_src(2, c2);
        step(); src_valid = '0;
        check("t2_ready",    64'(src_ready), 64'h7);
        step(); check("t2_rd0", 64'(wb_rd), 64'd10); check("t2_v0", 64'(wb_valid), 64'd1);
        step(); check("t2_rd1", 64'(wb_rd), 64'd11); check("t2_v1", 64'(wb_valid), 64'd1);
        step(); check("t2_rd2", 64'(wb_rd), 64'd12); check("t2_v2", 64'(wb_valid), 64'd1);
        step(); check("t2_idle", 64'(wb_valid), 64'd0);
        d0 = mk(7, 13, 32'h1234_5678, 500);
        expect_wb(d0); set_src(0, d0);
        step(); src_valid = '0;
        step(); check("t2_single_rd", 64'(wb_rd), 64'd13); check("t2_single_v", 64'(wb_valid), 64'd1);
        step();

        // Full FIFO on src 0 while srcs 1 and 2 hold the arbiter (pointer starts at 1)
        s0a = mk(8, 16, 32'hA, 600); s0b = mk(8, 17, 32'hB, 610); s0c = mk(8, 18, 32'hC, 620);
        s1a = mk(9, 19, 32'hD, 630); s1b = mk(9, 20, 32'hE, 640);
        s2a = mk(10, 21, 32'hF, 650); s2b = mk(10, 22, 32'h1, 660);
        expect_wb(s1a); expect_wb(s2a); expect_wb(s0a); expect_wb(s1b);
        expect_wb(s2b); expect_wb(s0b); expect_wb(s0c);
        set_src(0, s0a); set_src(1, s1a); set_src(2, s2a);
        step();
        check("t3_ready_e0", 64'(src_ready), 64'h7);
        set_src(0, s0b); set_src(1, s1b); set_src(2, s2b);
        step();
        check("t3_ready_e1", 64'(src_ready), 64'h2);
        src_valid = '0; set_src(0, s0c);
        step();
        check("t3_ready_e2", 64'(src_ready), 64'h6);
        step();
        check("t3_ready_e3", 64'(src_ready), 64'h7);
        step();
        src_valid = '0;
        check("t3_ready_e4", 64'(src_ready), 64'h6);
        for (int n = 0; n < 5; n++) step();
        check("t3_drained",  64'(wb_valid), 64'd0);

        // rdy low for four cycles with src 0 still pending (pointer starts at 1)
        s0x = mk(11, 24, 32'h55, 700); s2x = mk(12, 23, 32'hAA, 710);
        junk = mk(13, 31, 32'h3, 720);
        expect_wb(s2x); expect_wb(s0x);
        set_src(0, s0x); set_src(2, s2x);
        step(); src_valid = '0;
        step();
        check("t4_first_rd", 64'(wb_rd), 64'd23);
        rdy = 1'b0;
        set_src(1, junk);
        for (int n = 0; n < 4; n++) begin
            step();
            check("t4_hold_v",   64'(wb_valid), 64'd1);
            check("t4_hold_rd",  64'(wb_rd), 64'd23);
            check("t4_ready",    64'(src_ready), 64'h7);
        end
        src_valid = '0; rdy = 1'b1;
        step();
        check("t4_resume_rd", 64'(wb_rd), 64'd24);
        check("t4_resume_v",  64'(wb_valid), 64'd1);
        step();
        check("t4_idle",      64'(wb_valid), 64'd0);

        // Reset with two entries buffered in src 2; none may emerge
        set_src(0, mk(1, 25, 32'h1, 800)); set_src(1, mk(1, 26, 32'h1, 810));
        set_src(2, mk(1, 27, 32'h1, 820));
        step();
        src_valid = '0; set_src(2, mk(1, 28, 32'h1, 830));
        step();
        src_valid = '0;
        check("t5_ready_pre", 64'(src_ready), 64'h3);
        rst_n = 1'b0;
        #1;
        check("t5_wb_async",  64'(wb_valid), 64'd0);
        step(); step();
        rst_n = 1'b1;
        check("t5_ready",     64'(src_ready), 64'h7);
        for (int n = 0; n < 5; n++) begin
            step();
            check("t5_quiet", 64'(wb_valid), 64'd0);
        end

        // All-zero mask still forwarded
        z = mk(9, 29, 32'h0, 900);
        expect_wb(z); set_src(0, z);
        step(); src_valid = '0;
        step();
        check("t6_valid", 64'(wb_valid), 64'd1);
        check("t6_mask",  64'(wb_mask), 64'd0);
        check("t6_rd",    64'(wb_rd), 64'd29);
        step(); step();

        check("sb_empty",    64'(sb.size()), 64'd0);
        check("pulse_count", 64'(pulses), 64'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
